// File: rtl/cache_line_arbiter_if.sv
// cache_line_arbiter_if
// Bundles the icache, dcache and memory-side line signals of the cache line
// arbiter. The arbiter connects through the slave modport. The environment
// (caches plus cacheline adaptor, or a bench) connects through the master
// modport.
interface cache_line_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  // icache side (read only)
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // dcache side (read and writeback)
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // cacheline adaptor side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter
// Shares the single physical-memory line port between the icache (read only)
// and the dcache (read/write). The winning request is latched in IDLE, held
// on the memory side until mem_resp, and the response is routed back only to
// the granted cache. A DONE bubble follows every completion so the requester
// can drop its level request before the next IDLE sample.
//
// Optional feature macro: CACHE_ARB_RR_EN
//   defined   : round-robin between the caches when both request in the same
//               IDLE cycle (the one not equal to last_grant wins)
//   undefined : the dcache always wins; last_grant is still tracked
module cache_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  cache_line_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  state_t            state;
  grant_t            last_grant;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;

  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              i_done;
  logic              d_done;

  // Summarise the pending requests and choose which cache wins the IDLE sample
  always_comb begin
    i_req  = bus.i_read;
    d_req  = bus.d_read | bus.d_write;
    pick_d = 1'b0;
`ifdef CACHE_ARB_RR_EN
    pick_d = d_req && (!i_req || (last_grant == GRANT_I));
`else
    pick_d = d_req;
`endif
  end

  // A completion only counts if the granted cache is still asking for it
  always_comb begin
    i_done = (state == SERVE_I) && bus.mem_resp && i_req;
    d_done = (state == SERVE_D) && bus.mem_resp && d_req;
  end

  // Main FSM: latch the winner in IDLE, hold it until mem_resp, then bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            if (pick_d) begin
              state      <= SERVE_D;
              last_grant <= GRANT_D;
              addr_q     <= bus.d_address;
              wdata_q    <= bus.d_wdata;
              write_q    <= bus.d_write;
              read_q     <= ~bus.d_write;
            end else begin
              state      <= SERVE_I;
              last_grant <= GRANT_I;
              addr_q     <= bus.i_address;
              write_q    <= 1'b0;
              read_q     <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_resp) begin
            state   <= DONE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Remember the last line delivered to each cache so the idle side holds it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_done) begin
        i_rdata_q <= bus.mem_rdata;
      end
      if (d_done) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_read    = read_q;
  assign bus.mem_write   = write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  assign bus.i_resp  = i_done;
  assign bus.d_resp  = d_done;
  assign bus.i_rdata = i_done ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata = d_done ? bus.mem_rdata : d_rdata_q;

  // The serving state always agrees with the grant that was recorded
  ap_grant_i : assert property (@(posedge clk) disable iff (rst)
    (state == SERVE_I) |-> (last_grant == GRANT_I));

  ap_grant_d : assert property (@(posedge clk) disable iff (rst)
    (state == SERVE_D) |-> (last_grant == GRANT_D));

  // A memory request is never both a read and a write
  ap_op_onehot : assert property (@(posedge clk) disable iff (rst)
    !(read_q && write_q));

  // No memory request is presented outside the serving states
  ap_quiet_idle : assert property (@(posedge clk) disable iff (rst)
    ((state == IDLE) || (state == DONE)) |-> !(read_q || write_q));

endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb_cache_line_arbiter
// Directed scenarios with literal expectations, followed by randomized
// icache/dcache/adaptor traffic. A transaction-level reference model checks
// every DUT output on every falling edge.
module tb_cache_line_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk;
  logic rst;

  int checks;
  int errors;

  cache_line_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_line_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, LINE_W'(act), LINE_W'(exp));
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = $urandom();
    return a & 32'hFFFF_FFE0;
  endfunction

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = icache, 2 = dcache
  int                m_owner;
  bit                m_write;
  bit                m_bubble;
  int                m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_i_line;
  logic [LINE_W-1:0] m_d_line;

  always @(negedge clk) begin
    logic want_i, want_d, e_i, e_d;
    int   pick;
    if (rst) begin
      checkBit("rst_mem_read", bus.mem_read, 1'b0);
      checkBit("rst_mem_write", bus.mem_write, 1'b0);
      checkOutput("rst_mem_address", LINE_W'(bus.mem_address), '0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, '0);
      checkBit("rst_i_resp", bus.i_resp, 1'b0);
      checkBit("rst_d_resp", bus.d_resp, 1'b0);
      checkOutput("rst_i_rdata", bus.i_rdata, '0);
      checkOutput("rst_d_rdata", bus.d_rdata, '0);
      m_owner  = 0;
      m_write  = 1'b0;
      m_bubble = 1'b0;
      m_last   = 1;
      m_addr   = '0;
      m_wdata  = '0;
      m_i_line = '0;
      m_d_line = '0;
    end else begin
      want_i = bus.i_read;
      want_d = bus.d_read | bus.d_write;
      e_i = (m_owner == 1) && bus.mem_resp && want_i;
      e_d = (m_owner == 2) && bus.mem_resp && want_d;
      checkBit("mdl_mem_read", bus.mem_read, (m_owner != 0) && !m_write);
      checkBit("mdl_mem_write", bus.mem_write, (m_owner != 0) && m_write);
      checkOutput("mdl_mem_address", LINE_W'(bus.mem_address), LINE_W'(m_addr));
      if (m_owner == 2 && m_write) checkOutput("mdl_mem_wdata", bus.mem_wdata, m_wdata);
      checkBit("mdl_i_resp", bus.i_resp, e_i);
      checkBit("mdl_d_resp", bus.d_resp, e_d);
      checkOutput("mdl_i_rdata", bus.i_rdata, e_i ? bus.mem_rdata : m_i_line);
      checkOutput("mdl_d_rdata", bus.d_rdata, e_d ? bus.mem_rdata : m_d_line);
      // what the upcoming rising edge does
      if (e_i) m_i_line = bus.mem_rdata;
      if (e_d) m_d_line = bus.mem_rdata;
      if (m_owner != 0) begin
        if (bus.mem_resp) begin
          m_owner  = 0;
          m_bubble = 1'b1;
        end
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (want_i || want_d) begin
`ifdef CACHE_ARB_RR_EN
        if (want_i && want_d) pick = (m_last == 2) ? 1 : 2;
        else pick = want_d ? 2 : 1;
`else
        pick = want_d ? 2 : 1;
`endif
        m_owner = pick;
        m_last  = pick;
        if (pick == 2) begin
          m_addr  = bus.d_address;
          m_wdata = bus.d_wdata;
          m_write = bus.d_write;
        end else begin
          m_addr  = bus.i_address;
          m_write = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle whose end samples the expected winner.
  // Serves it with a one-cycle latency, checks routing, drops its request,
  // and returns in the following IDLE cycle.
  task automatic serveAndCheck(input logic [ADDR_W-1:0] exp_addr, input bit exp_d,
                               input string tag);
    logic [LINE_W-1:0] line;
    step();
    line          = rand_line();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = line;
    @(negedge clk);
    checkOutput({tag, "_addr"}, LINE_W'(bus.mem_address), LINE_W'(exp_addr));
    checkBit({tag, "_i_resp"}, bus.i_resp, !exp_d);
    checkBit({tag, "_d_resp"}, bus.d_resp, exp_d);
    checkOutput({tag, "_rdata"}, exp_d ? bus.d_rdata : bus.i_rdata, line);
    step();
    bus.mem_resp = 1'b0;
    if (exp_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read = 1'b0;
    end
    step();
  endtask

  // One randomized cycle of icache, dcache and adaptor behaviour
  task automatic applyStimulus(input logic saw_i, input logic saw_d);
    int k;
    if (bus.i_read) begin
      if (saw_i || $urandom_range(0, 19) == 0) bus.i_read = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.i_read    = 1'b1;
      bus.i_address = rand_addr();
    end
    if (bus.d_read || bus.d_write) begin
      if (saw_d || $urandom_range(0, 19) == 0) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        bus.d_wdata = rand_line();
      end
    end else if ($urandom_range(0, 2) == 0) begin
      k             = $urandom_range(0, 9);
      bus.d_write   = (k < 5);
      bus.d_read    = (k >= 5) || (k == 0);
      bus.d_address = rand_addr();
      bus.d_wdata   = rand_line();
    end
    bus.mem_resp  = ($urandom_range(0, 3) == 0);
    bus.mem_rdata = rand_line();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_beef;
    logic              saw_i, saw_d;
    logic [ADDR_W-1:0] first_addr, second_addr;
    bit                first_d;
    checks = 0;
    errors = 0;
    pat_a5   = {32{8'hA5}};
    pat_beef = {8{32'hDEADBEEF}};

    rst           = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    $display("[TB] single icache read");
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0060;
    step();
    @(negedge clk);
    checkBit("t1_mem_read_rise", bus.mem_read, 1'b1);
    checkOutput("t1_mem_address", LINE_W'(bus.mem_address), LINE_W'(32'h0000_0060));
    repeat (4) step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = pat_a5;
    @(negedge clk);
    checkBit("t1_i_resp", bus.i_resp, 1'b1);
    checkOutput("t1_i_rdata", bus.i_rdata, pat_a5);
    checkBit("t1_d_resp", bus.d_resp, 1'b0);
    step();
    bus.mem_resp = 1'b0;
    bus.i_read   = 1'b0;
    @(negedge clk);
    checkBit("t1_mem_read_fall", bus.mem_read, 1'b0);
    checkBit("t1_i_resp_once", bus.i_resp, 1'b0);
    step();

    $display("[TB] dcache writeback");
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_1F80;
    bus.d_wdata   = pat_beef;
    step();
    @(negedge clk);
    checkBit("t2_mem_write", bus.mem_write, 1'b1);
    checkOutput("t2_mem_wdata", bus.mem_wdata, pat_beef);
    step();
    bus.d_wdata = '0;
    step();
    @(negedge clk);
    checkOutput("t2_wdata_held", bus.mem_wdata, pat_beef);
    checkOutput("t2_addr_held", LINE_W'(bus.mem_address), LINE_W'(32'h0000_1F80));
    step();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    checkBit("t2_d_resp", bus.d_resp, 1'b1);
    step();
    bus.mem_resp = 1'b0;
    bus.d_write  = 1'b0;
    @(negedge clk);
    checkBit("t2_d_resp_once", bus.d_resp, 1'b0);
    checkBit("t2_mem_write_fall", bus.mem_write, 1'b0);
    step();

    $display("[TB] simultaneous requests");
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0100;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_0200;
`ifdef CACHE_ARB_RR_EN
    first_d     = 1'b0;
    first_addr  = 32'h0000_0100;
    second_addr = 32'h0000_0200;
`else
    first_d     = 1'b1;
    first_addr  = 32'h0000_0200;
    second_addr = 32'h0000_0100;
`endif
    serveAndCheck(first_addr, first_d, "t3_first");
    serveAndCheck(second_addr, !first_d, "t3_second");

`ifdef CACHE_ARB_RR_EN
    $display("[TB] round-robin fairness");
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0480;
    serveAndCheck(32'h0000_0480, 1'b0, "t4_prime");
    bus.i_address = 32'h0000_0400;
    bus.d_address = 32'h0000_0300;
    for (int t = 0; t < 4; t++) begin
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      if (t % 2 == 0) serveAndCheck(32'h0000_0300, 1'b1, "t4_rr_d");
      else serveAndCheck(32'h0000_0400, 1'b0, "t4_rr_i");
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    step();
`endif

    $display("[TB] abandoned icache request");
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0080;
    step();
    step();
    step();
    bus.i_read = 1'b0;
    step();
    step();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    checkBit("t5_mem_read_held", bus.mem_read, 1'b1);
    checkBit("t5_no_i_resp", bus.i_resp, 1'b0);
    step();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    checkBit("t5_mem_read_fall", bus.mem_read, 1'b0);
    step();
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_0500;
    serveAndCheck(32'h0000_0500, 1'b1, "t5_after");

    $display("[TB] reset during dcache writeback");
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_0600;
    bus.d_wdata   = rand_line();
    step();
    @(negedge clk);
    checkBit("t6_mem_write_pre", bus.mem_write, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkBit("t6_mem_write_async", bus.mem_write, 1'b0);
    checkBit("t6_no_d_resp", bus.d_resp, 1'b0);
    checkOutput("t6_addr_async", LINE_W'(bus.mem_address), '0);
    @(posedge clk);
    @(negedge clk);
    step();
    rst         = 1'b0;
    bus.d_write = 1'b0;

    $display("[TB] spurious mem_resp in IDLE");
    step();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    checkBit("t7_no_i_resp", bus.i_resp, 1'b0);
    checkBit("t7_no_d_resp", bus.d_resp, 1'b0);
    checkBit("t7_no_mem_read", bus.mem_read, 1'b0);
    step();
    bus.mem_resp  = 1'b0;
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0700;
    serveAndCheck(32'h0000_0700, 1'b0, "t7_after");

    $display("[TB] randomized traffic");
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      saw_i = bus.i_resp;
      saw_d = bus.d_resp;
      step();
      applyStimulus(saw_i, saw_d);
    end
    bus.i_read   = 1'b0;
    bus.d_read   = 1'b0;
    bus.d_write  = 1'b0;
    bus.mem_resp = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (read only) and the data cache (read/write) in the pipelined RISC-V core.
- Sits between the two L1 caches and the cacheline adaptor, which does the burst conversion.
- Latches the winning request, holds it on the memory side until mem_resp, then routes the response back to the granted cache only.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- LINE_W, 256, cache line width for the rdata/wdata buses.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  icache line read request, level, held until i_resp
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  one-cycle completion to icache
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache writeback request, held until d_resp
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  one-cycle completion to dcache
- mem_read  out  1  read request to cacheline adaptor
- mem_write  out  1  write request to cacheline adaptor
- mem_address  out  ADDR_W  latched address of granted request
- mem_wdata  out  LINE_W  latched write data
- mem_rdata  in  LINE_W  line data from adaptor
- mem_resp  in  1  one-cycle completion from adaptor

Behaviour:
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0. FSM goes to IDLE. last_grant=ICACHE.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE, sampling on cycle n:
  - If a request is pending, latch address, wdata and op (read/write) of the winner into registers.
  - Go to SERVE_I or SERVE_D.
  - mem_read/mem_write are driven from the registered op and are asserted from cycle n+1.
- Arbitration (feature off): d_read|d_write wins over i_read.
- A d_read and d_write asserted together is a protocol error. Write takes precedence, and the op is latched as write.
- SERVE_x:
  - mem_read/mem_write and mem_address/mem_wdata are held stable from the latched registers until mem_resp.
  - Requester inputs are ignored while in SERVE_x.
- On mem_resp in SERVE_x:
  - Same cycle, combinationally: x_resp=1 and x_rdata=mem_rdata.
  - The other cache's resp stays 0 and its rdata holds its last value.
  - Next state is DONE. mem_read/mem_write deassert in the next cycle.
- DONE:
  - One bubble cycle so the requester drops its request before re-sampling.
  - No memory request is issued in DONE. Always returns to IDLE.
- Back-to-back cost: minimum 3 cycles of arbiter overhead between successive memory requests (mem_resp cycle, DONE, IDLE).
- Abandoned request: if the granted requester deasserts before mem_resp, the arbiter still holds the memory request until mem_resp. It discards the data (x_resp not asserted), then passes through DONE.
- Spurious mem_resp in IDLE or DONE is ignored.
- rst asserted mid-transaction:
  - All outputs return to reset values immediately and asynchronously; the FSM goes to IDLE.
  - No resp is issued for the in-flight request.
  - The adaptor is reset by the same rst.
- last_grant updates on every transition out of IDLE.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: round-robin arbitration when both caches request in the same IDLE cycle. The requester not equal to last_grant wins; a single requester always wins.
- Undefined: fixed dcache priority; last_grant is still maintained but not used for arbitration.

Test Plan:
- Single icache read: i_read=1, i_address=0x0000_0060; mem_resp after 5 cycles with mem_rdata=0xA5 repeated.
  - Required: mem_read rises the cycle after i_read is sampled, and mem_address=0x0000_0060.
  - Required: i_resp=1 for exactly 1 cycle with i_rdata=mem_rdata; d_resp stays 0; mem_read=0 the cycle after mem_resp.
- Dcache writeback: d_write=1, d_address=0x0000_1F80, d_wdata=0xDEADBEEF repeated.
  - Required: mem_write=1 and mem_wdata matches, held stable until mem_resp even if d_wdata is changed to 0 mid-request.
  - Required: then d_resp=1 for 1 cycle.
- Simultaneous requests: i_read and d_read both asserted in the same IDLE cycle, held.
  - Feature off: dcache served first, then icache.
  - Feature on with last_grant=DCACHE: icache first.
  - Both builds: exactly one i_resp and one d_resp.
- Starvation check (feature on): d_read held continuously and re-asserted each time, i_read held.
  - Required: grants alternate D,I,D,I over 4 transactions.
- Abandon and reset:
  - Icache deasserts i_read 2 cycles into SERVE_I. Required: mem_read held until mem_resp, no i_resp, FSM passes through DONE to IDLE.
  - Separately, rst pulsed while in SERVE_D. Required: mem_write=0 immediately and no d_resp.
- Spurious mem_resp pulsed while in IDLE with no requests -> no i_resp or d_resp, FSM stays IDLE.
